// File: rtl/fp_pkg.sv
// Shared FPU package: multiplier state encoding, status codes and format constants.
// Used by fmul_seq, fmul_round and the float divider.
package fp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL,
        S_NORM,
        S_DONE
    } fmul_state_t;

    localparam logic [1:0] FP_OK  = 2'b00;
    localparam logic [1:0] FP_OVF = 2'b01;
    localparam logic [1:0] FP_UDF = 2'b10;
    localparam logic [1:0] FP_INV = 2'b11;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    localparam logic [31:0] FP_ERR_Z = 32'h00000001;

endpackage

// File: rtl/fmul_round.sv
// Combinational normalize, round and range check of the 48-bit mantissa product.
// Ports: p (product), e (signed exponent), s (sign) -> z (packed result), status.
// Macro FMUL_ROUND_EN selects round-to-nearest-even; otherwise truncation.
module fmul_round
    import fp_pkg::*;
(
    input  logic [47:0]        p,
    input  logic signed [9:0]  e,
    input  logic               s,
    output logic [31:0]        z,
    output logic [1:0]         status
);

    localparam logic signed [9:0] E_MAX = 10'(FP_EXP_MAX);

    logic              hi;
    logic [22:0]       mant;
    logic signed [9:0] e_n;
    logic [22:0]       mant_r;
    logic signed [9:0] e_r;

    assign hi   = p[47];
    assign mant = hi ? p[46:24] : p[45:23];
    assign e_n  = e + $signed({9'b0, hi});

`ifdef FMUL_ROUND_EN
    logic        guard;
    logic        sticky;
    logic        inc;
    logic [23:0] sum;

    assign guard  = hi ? p[23] : p[22];
    assign sticky = hi ? |p[22:0] : |p[21:0];
    assign inc    = guard & (sticky | mant[0]);
    assign sum    = {1'b0, mant} + {23'b0, inc};
    // A carry-out leaves the fraction at zero; only the exponent bumps.
    assign mant_r = sum[22:0];
    assign e_r    = e_n + $signed({9'b0, sum[23]});
`else
    logic unused_bits;

    assign unused_bits = ^p[22:0];
    assign mant_r      = mant;
    assign e_r         = e_n;
`endif

    always_comb begin
        z      = '0;
        status = FP_OK;
        if (e_r >= E_MAX) begin
            z      = {s, 8'hFF, 23'b0};
            status = FP_OVF;
        end else if (e_r <= 10'sd0) begin
            z      = {s, 31'b0};
            status = FP_UDF;
        end else begin
            z      = {s, e_r[7:0], mant_r};
            status = FP_OK;
        end
    end

endmodule

// File: rtl/fmul_seq.sv
// Sequential IEEE-754 single multiplier, shift-and-add one bit per clock.
// Ports: clk, rst (sync, active-low), start, x, y -> busy, done, z, overflow.
// Macro FMUL_ROUND_EN enables round-to-nearest-even (see fmul_round).
module fmul_seq
    import fp_pkg::*;
#(
    parameter int EXP_BIAS = FP_BIAS,
    parameter int ITER     = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [1:0]  overflow
);

    localparam logic [4:0]        LAST   = 5'(ITER - 1);
    localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);

    fmul_state_t       state;
    logic [31:0]       xr;
    logic [31:0]       yr;
    logic [23:0]       mc;
    logic [23:0]       mr;
    logic [47:0]       acc;
    logic [4:0]        cnt;
    logic signed [9:0] e;
    logic              s;
    logic [31:0]       rz;
    logic [1:0]        rstat;
    logic              x_inv;
    logic              y_inv;
    logic              x_zero;
    logic              y_zero;

    assign x_inv  = (xr[30:23] == 8'hFF) || (xr[30:23] == 8'h00 && xr[22:0] != 23'b0);
    assign y_inv  = (yr[30:23] == 8'hFF) || (yr[30:23] == 8'h00 && yr[22:0] != 23'b0);
    assign x_zero = (xr[30:0] == 31'b0);
    assign y_zero = (yr[30:0] == 31'b0);

    fmul_round u_round (
        .p      (acc),
        .e      (e),
        .s      (s),
        .z      (rz),
        .status (rstat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            xr       <= '0;
            yr       <= '0;
            mc       <= '0;
            mr       <= '0;
            acc      <= '0;
            cnt      <= '0;
            e        <= '0;
            s        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            z        <= '0;
            overflow <= FP_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (x_inv || y_inv) begin
                        z        <= FP_ERR_Z;
                        overflow <= FP_INV;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else if (x_zero || y_zero) begin
                        z        <= {xr[31] ^ yr[31], 31'b0};
                        overflow <= FP_OK;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        mc    <= {1'b1, xr[22:0]};
                        mr    <= {1'b1, yr[22:0]};
                        e     <= $signed({2'b0, xr[30:23]})
                               + $signed({2'b0, yr[30:23]}) - BIAS10;
                        s     <= xr[31] ^ yr[31];
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mr[0]) begin
                        acc <= acc + ({24'b0, mc} << cnt);
                    end
                    mr  <= mr >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= S_NORM;
                    end
                end
                S_NORM: begin
                    z        <= rz;
                    overflow <= rstat;
                    done     <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: arithmetic model plus directed vectors.
// Build with or without FMUL_ROUND_EN; expectations follow the same macro.
module tb_fmul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic        busy;
    logic        done;
    logic [31:0] z;
    logic [1:0]  overflow;

    int n_pass = 0;
    int n_total = 0;
    bit armed = 1'b0;

    fmul_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .z        (z),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Arithmetic reference: exact integer product, rounding judged by
    // comparing the discarded remainder against one half ulp.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rz, output logic [1:0] ro);
        int ea, eb, e, sh;
        longint ma, mb, p, q, rem, half;
        logic sg;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sg = a[31] ^ b[31];
        if (ea == 255 || eb == 255 || (ea == 0 && a[22:0] != 0) || (eb == 0 && b[22:0] != 0)) begin
            rz = 32'h00000001; ro = 2'b11; return;
        end
        if (ea == 0 || eb == 0) begin
            rz = {sg, 31'b0}; ro = 2'b00; return;
        end
        ma = longint'(8388608) + longint'(a[22:0]);
        mb = longint'(8388608) + longint'(b[22:0]);
        p = ma * mb;
        e = ea + eb - 127;
        sh = (p >= (longint'(1) << 47)) ? 24 : 23;
        e = e + sh - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = longint'(1) << (sh - 1);
`ifdef FMUL_ROUND_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
`else
        if (rem < 0) q = 0;
`endif
        if (e >= 255) begin
            rz = {sg, 8'hFF, 23'b0}; ro = 2'b01;
        end else if (e <= 0) begin
            rz = {sg, 31'b0}; ro = 2'b10;
        end else begin
            rz = {sg, 8'(e), q[22:0]}; ro = 2'b00;
        end
    endfunction

    // Cycle-level expectation: a result appears 26 edges (normal) or
    // 1 edge (special) after acceptance; start is ignored while busy.
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [31:0] m_z = '0;
    logic [1:0]  m_o = '0;
    logic [31:0] p_z;
    logic [1:0]  p_o;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_left = 0; m_z = '0; m_o = '0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1; m_z = p_z; m_o = p_o;
            end
        end else if (start) begin
            model(x, y, p_z, p_o);
            m_busy = 1;
            m_left = (x[30:23] == 0 || y[30:23] == 0 || x[30:23] == 255 || y[30:23] == 255) ? 1 : 26;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_z", z, m_z);
            chk("cyc_ovf", {30'b0, overflow}, {30'b0, m_o});
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ez, input logic [1:0] eo,
                          input int lat, input int poke);
        logic [31:0] mz;
        logic [1:0]  mo;
        int n, bc;
        model(a, b, mz, mo);
        chk({name, "_model_z"}, mz, ez);
        chk({name, "_model_ovf"}, {30'b0, mo}, {30'b0, eo});
        @(negedge clk);
        x = a; y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; bc = 0;
        while (!done && n < 60) begin
            if (busy) bc++;
            start = (n == poke);
            if (n == poke) begin x = 32'h7FC00000; y = 32'h3F800000; end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (busy) bc++;
        chk({name, "_latency"}, 32'(n), 32'(lat));
        chk({name, "_busy_cycles"}, 32'(bc), 32'(lat + 1));
        chk({name, "_z"}, z, ez);
        chk({name, "_ovf"}, {30'b0, overflow}, {30'b0, eo});
        @(negedge clk);
        chk({name, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1 armed = 1'b1;
        chk("reset_z", z, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 26, -1);
        run_op("mul_neg", 32'hBFC00000, 32'h40000000, 32'hC0400000, 2'b00, 26, -1);
        run_op("ovf", 32'h7F000000, 32'h40000000, 32'h7F800000, 2'b01, 26, -1);
        run_op("udf", 32'h00800000, 32'h00800000, 32'h00000000, 2'b10, 26, -1);
        run_op("nan", 32'h7FC00000, 32'h3F800000, 32'h00000001, 2'b11, 1, -1);
        run_op("neg_zero", 32'h80000000, 32'h40000000, 32'h80000000, 2'b00, 1, -1);
`ifdef FMUL_ROUND_EN
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 2'b00, 26, -1);
`else
        run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 2'b00, 26, -1);
`endif
        run_op("mul_1x1", 32'h3F800000, 32'hBF800000, 32'hBF800000, 2'b00, 26, -1);
        run_op("busy_start", 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 26, 8);

        @(negedge clk);
        x = 32'h40000000; y = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_z", z, 32'h0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        rst = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        run_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 26, -1);

        repeat (2) @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
